// File: rtl/uart_flow_tx.sv
// uart_flow_tx: host-side UART transmitter with CTS flow control.
// Bytes enter over a valid/ready stream, are buffered in a small FIFO and
// are serialised LSB-first as 8N1 (8N2 with STOP_BITS=2).
// Optional macro UART_PARITY_EN: inserts one even-parity bit after the
// data bits (8E1 / 8E2).
// Timing: tx, busy and tx_led are registered copies of the FSM state, so
// the line follows the state register by one clock. Every bit, frame and
// gap therefore keeps its exact length.
module uart_flow_tx #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  input  logic                          cts,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_led
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [15:0]      BIT_LOAD  = 16'(BAUD_DIV - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic [LVL_W-1:0] level_next;
  logic             wr_ready_reg;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  // CTS synchroniser
  logic [1:0]       cts_sync_reg;
  logic             cts_s;

  // Transmit FSM and datapath
  state_t           state_reg;
  state_t           state_next;
  logic [15:0]      timer_reg;
  logic [15:0]      timer_next;
  logic [2:0]       idx_reg;
  logic [2:0]       idx_next;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_next;
`ifdef UART_PARITY_EN
  logic             parity_reg;
  logic             parity_next;
`endif
  logic             bit_end;
  logic             tx_bit;
  logic             tx_reg;
  logic             busy_reg;

  // wr_ready comes from the registered level, so a full FIFO refuses a push
  // even in the cycle it pops; space appears on the following cycle.
  assign push  = wr_valid && wr_ready_reg;
  assign head  = mem[rd_ptr_reg];
  assign cts_s = cts_sync_reg[1];

  // Next FIFO occupancy from this cycle's push/pop pair
  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  // FIFO data array; no reset so it maps onto plain memory
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // FIFO pointers, level and ready flag; pointers wrap naturally at depth
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      wr_ready_reg <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      level_reg    <= level_next;
      wr_ready_reg <= (level_next != LVL_FULL);
    end
  end

  // Two-flop synchroniser for the asynchronous, active-low CTS input
  always_ff @(posedge clk) begin
    if (!reset) begin
      cts_sync_reg <= 2'b11;
    end else begin
      cts_sync_reg <= {cts_sync_reg[0], cts};
    end
  end

  // FSM state, bit timer, shifter and registered line outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
`ifdef UART_PARITY_EN
      parity_reg <= 1'b0;
`endif
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
`ifdef UART_PARITY_EN
      parity_reg <= parity_next;
`endif
      tx_reg     <= tx_bit;
      busy_reg   <= (state_reg != IDLE);
    end
  end

  // Next-state logic: frame sequencing, bit timing and line level
  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
`ifdef UART_PARITY_EN
    parity_next = parity_reg;
`endif
    pop         = 1'b0;
    tx_bit      = 1'b1;
    bit_end     = (timer_reg == 16'd0);

    case (state_reg)
      IDLE: begin
        tx_bit = 1'b1;
        if ((level_reg != '0) && !cts_s) begin
          pop         = 1'b1;
          shift_next  = head;
`ifdef UART_PARITY_EN
          parity_next = ^head;
`endif
          timer_next  = BIT_LOAD;
          state_next  = START;
        end
      end

      START: begin
        tx_bit = 1'b0;
        if (bit_end) begin
          timer_next = BIT_LOAD;
          idx_next   = 3'd0;
          state_next = DATA;
        end else begin
          timer_next = timer_reg - 16'd1;
        end
      end

      DATA: begin
        tx_bit = shift_reg[0];
        if (bit_end) begin
          timer_next = BIT_LOAD;
          shift_next = {1'b0, shift_reg[7:1]};
          if (idx_reg == 3'd7) begin
            idx_next   = 3'd0;
`ifdef UART_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          timer_next = timer_reg - 16'd1;
        end
      end

`ifdef UART_PARITY_EN
      PARITY: begin
        tx_bit = parity_reg;
        if (bit_end) begin
          timer_next = BIT_LOAD;
          idx_next   = 3'd0;
          state_next = STOP;
        end else begin
          timer_next = timer_reg - 16'd1;
        end
      end
`endif

      STOP: begin
        // idx counts stop bits here
        tx_bit = 1'b1;
        if (bit_end) begin
          if (idx_reg == STOP_LAST) begin
            idx_next   = 3'd0;
            state_next = IDLE;
          end else begin
            idx_next   = idx_reg + 3'd1;
            timer_next = BIT_LOAD;
          end
        end else begin
          timer_next = timer_reg - 16'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign tx_led     = busy_reg;
  assign wr_ready   = wr_ready_reg;
  assign fifo_level = level_reg;

endmodule

// File: tb/tb_uart_flow_tx.sv
// tb_uart_flow_tx: self-checking bench for uart_flow_tx (BAUD_DIV=4,
// FIFO_DEPTH=8, STOP_BITS=1). Expected line waveforms come from a bit-list
// model of the UART frame; honours UART_PARITY_EN like the design.
module tb_uart_flow_tx;

  localparam int BAUD  = 4;
  localparam int DEPTH = 8;
  localparam int STOPB = 1;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_CYC = (9 + STOPB + PAR) * BAUD;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          tx;
  logic          cts = 1'b1;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          tx_led;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model_q[$];

  uart_flow_tx #(
    .BAUD_DIV  (BAUD),
    .FIFO_DEPTH(DEPTH),
    .STOP_BITS (STOPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .tx        (tx),
    .cts       (cts),
    .busy      (busy),
    .fifo_level(fifo_level),
    .tx_led    (tx_led)
  );

  always #5 clk = ~clk;

  // Reference frame: start, 8 data bits LSB first, optional even parity,
  // stop bits; each bit held for BAUD cycles.
  function automatic logic [FRAME_CYC-1:0] model_wave(input logic [7:0] b);
    logic [FRAME_CYC-1:0] w;
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_PARITY_EN
    bits.push_back(($countones(b) % 2) == 1);
`endif
    for (int s = 0; s < STOPB; s++) bits.push_back(1'b1);
    w = '0;
    for (int k = 0; k < bits.size(); k++)
      for (int c = 0; c < BAUD; c++) w[k*BAUD + c] = bits[k];
    return w;
  endfunction

  // Wait (bounded) for a start bit, then record tx for one frame length.
  task automatic capture_frame(output logic [FRAME_CYC-1:0] wave, output int wait_cyc,
                               output int busy_cyc, output int led_cyc, output bit timed_out);
    wave = '0; wait_cyc = 0; busy_cyc = 0; led_cyc = 0; timed_out = 1'b0;
    while (tx !== 1'b0) begin
      if (wait_cyc >= 400) begin
        timed_out = 1'b1;
        return;
      end
      wait_cyc++;
      @(negedge clk);
    end
    for (int i = 0; i < FRAME_CYC; i++) begin
      wave[i] = tx;
      if (busy === 1'b1) busy_cyc++;
      if (tx_led === 1'b1) led_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; cts = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b want 1", tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (tx_led !== 1'b0) begin miscompares++; $display("FAIL reset_led got %b want 0", tx_led); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", wr_ready); end
    vectors++; if (fifo_level !== LW'(0)) begin miscompares++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single;
    logic [FRAME_CYC-1:0] w; int wc, bc, lc; bit to;
    wr_data = 8'hA5; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    vectors++; if (fifo_level !== LW'(1)) begin miscompares++; $display("FAIL single_level got %0d want 1", fifo_level); end
    capture_frame(w, wc, bc, lc, to);
    vectors++; if (to) begin miscompares++; $display("FAIL single_timeout got none want start bit"); end
    vectors++; if (wc != 2) begin miscompares++; $display("FAIL single_latency got %0d want 2", wc); end
    vectors++; if (w !== model_wave(8'hA5)) begin miscompares++; $display("FAIL single_wave got %h want %h", w, model_wave(8'hA5)); end
    vectors++; if (bc != FRAME_CYC) begin miscompares++; $display("FAIL single_busy got %0d want %0d", bc, FRAME_CYC); end
    vectors++; if (lc != FRAME_CYC) begin miscompares++; $display("FAIL single_led got %0d want %0d", lc, FRAME_CYC); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_end_busy got %b want 0", busy); end
    vectors++; if (fifo_level !== LW'(0)) begin miscompares++; $display("FAIL single_end_level got %0d want 0", fifo_level); end
    $display("test_single byte=a5 wait=%0d busy=%0d", wc, bc);
  endtask

  task automatic test_queued;
    logic [7:0] bytes[3];
    logic [FRAME_CYC-1:0] w; int wc, bc, lc; bit to;
    bytes[0] = 8'h55; bytes[1] = 8'h0F; bytes[2] = 8'hF0;
    cts = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wr_data = bytes[i]; wr_valid = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (tx !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL queued_hold got tx=%b busy=%b want tx=1 busy=0", tx, busy); end
    vectors++; if (fifo_level !== LW'(3)) begin miscompares++; $display("FAIL queued_level got %0d want 3", fifo_level); end
    cts = 1'b0;
    for (int k = 0; k < 3; k++) begin
      capture_frame(w, wc, bc, lc, to);
      vectors++; if (to) begin miscompares++; $display("FAIL queued_timeout frame %0d got none want start", k); end
      vectors++; if (w !== model_wave(bytes[k])) begin miscompares++; $display("FAIL queued_wave frame %0d got %h want %h", k, w, model_wave(bytes[k])); end
      vectors++;
      if (k == 0) begin
        if (wc != 4) begin miscompares++; $display("FAIL queued_cts_latency got %0d want 4", wc); end
      end else begin
        if (wc != 1) begin miscompares++; $display("FAIL queued_gap frame %0d got %0d want 1", k, wc); end
      end
      $display("test_queued frame %0d byte=%h wait=%0d", k, bytes[k], wc);
    end
  endtask

  task automatic test_fill;
    logic [7:0] sent[12];
    bit rdy_hist[$];
    int ready_cnt, n;
    logic [FRAME_CYC-1:0] w; int wc, bc, lc; bit to;
    cts = 1'b1;
    repeat (4) @(negedge clk);
    ready_cnt = 0;
    wr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sent[i] = 8'($urandom_range(0, 255));
      wr_data = sent[i];
      if (wr_ready === 1'b1) ready_cnt++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    vectors++; if (ready_cnt != DEPTH) begin miscompares++; $display("FAIL fill_accepted got %0d want %0d", ready_cnt, DEPTH); end
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready got %b want 0", wr_ready); end
    vectors++; if (fifo_level !== LW'(DEPTH)) begin miscompares++; $display("FAIL fill_level got %0d want %0d", fifo_level, DEPTH); end
    cts = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      rdy_hist.push_back(wr_ready);
      n++;
      @(negedge clk);
    end
    vectors++;
    if (rdy_hist.size() < 2 || tx !== 1'b0) begin
      miscompares++; $display("FAIL fill_start got no start bit want start within 100 cycles");
    end else begin
      if (rdy_hist[rdy_hist.size()-1] !== 1'b1 || rdy_hist[rdy_hist.size()-2] !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_ready_rise got %b%b want 01", rdy_hist[rdy_hist.size()-2], rdy_hist[rdy_hist.size()-1]);
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      capture_frame(w, wc, bc, lc, to);
      vectors++; if (to) begin miscompares++; $display("FAIL fill_timeout frame %0d got none want start", k); end
      vectors++; if (w !== model_wave(sent[k])) begin miscompares++; $display("FAIL fill_wave frame %0d got %h want %h", k, w, model_wave(sent[k])); end
      if (k > 0) begin
        vectors++; if (wc != 1) begin miscompares++; $display("FAIL fill_gap frame %0d got %0d want 1", k, wc); end
      end
      $display("test_fill frame %0d byte=%h wait=%0d", k, sent[k], wc);
    end
    vectors++; if (fifo_level !== LW'(0)) begin miscompares++; $display("FAIL fill_drain got %0d want 0", fifo_level); end
  endtask

  task automatic test_cts_mid;
    logic [7:0] b1;
    int bad;
    logic [FRAME_CYC-1:0] w; int wc, bc, lc; bit to;
    b1 = 8'($urandom_range(0, 255));
    cts = 1'b0;
    wr_data = 8'h3C; wr_valid = 1'b1;
    @(negedge clk);
    wr_data = b1;
    @(negedge clk);
    wr_valid = 1'b0;
    fork
      capture_frame(w, wc, bc, lc, to);
      begin
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 400) begin n++; @(negedge clk); end
        repeat (3 * BAUD) @(negedge clk);
        cts = 1'b1;
      end
    join
    vectors++; if (to) begin miscompares++; $display("FAIL ctsmid_timeout got none want start"); end
    vectors++; if (w !== model_wave(8'h3C)) begin miscompares++; $display("FAIL ctsmid_wave got %h want %h", w, model_wave(8'h3C)); end
    vectors++; if (bc != FRAME_CYC) begin miscompares++; $display("FAIL ctsmid_busy got %0d want %0d", bc, FRAME_CYC); end
    bad = 0;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL ctsmid_hold got %0d active cycles want 0", bad); end
    vectors++; if (fifo_level !== LW'(1)) begin miscompares++; $display("FAIL ctsmid_level got %0d want 1", fifo_level); end
    cts = 1'b0;
    capture_frame(w, wc, bc, lc, to);
    vectors++; if (to || w !== model_wave(b1)) begin miscompares++; $display("FAIL ctsmid_next got %h want %h", w, model_wave(b1)); end
    $display("test_cts_mid byte0=3c byte1=%h", b1);
  endtask

  task automatic test_reset_mid;
    int n, bad;
    cts = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    wr_valid = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 400) begin n++; @(negedge clk); end
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL rstmid_start got %b want 0", tx); end
    repeat (4 * BAUD + 1) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx got %b want 1", tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", busy); end
    vectors++; if (fifo_level !== LW'(0)) begin miscompares++; $display("FAIL rstmid_level got %0d want 0", fifo_level); end
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL rstmid_residual got %0d active cycles want 0", bad); end
    $display("test_reset_mid residual_cycles=%0d", bad);
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    logic [7:0] bytes[2];
    bit par_exp[2];
    logic [FRAME_CYC-1:0] w; int wc, bc, lc; bit to;
    bytes[0] = 8'h07; par_exp[0] = 1'b1;
    bytes[1] = 8'h03; par_exp[1] = 1'b0;
    cts = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wr_data = bytes[k]; wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
      capture_frame(w, wc, bc, lc, to);
      vectors++; if (to || w[9*BAUD] !== par_exp[k]) begin miscompares++; $display("FAIL parity_bit byte %h got %b want %b", bytes[k], w[9*BAUD], par_exp[k]); end
      vectors++; if (w !== model_wave(bytes[k])) begin miscompares++; $display("FAIL parity_wave got %h want %h", w, model_wave(bytes[k])); end
      vectors++; if (bc != 11 * BAUD) begin miscompares++; $display("FAIL parity_len got %0d want %0d", bc, 11 * BAUD); end
      $display("test_parity byte=%h parity=%b", bytes[k], w[9*BAUD]);
      repeat (2) @(negedge clk);
    end
  endtask
`endif

  task automatic test_random;
    localparam int NB = 10;
    cts = 1'b0;
    model_q.delete();
    fork
      begin
        for (int i = 0; i < NB; i++) begin
          int n;
          logic [7:0] b;
          b = 8'($urandom_range(0, 255));
          wr_data = b; wr_valid = 1'b1;
          n = 0;
          while (wr_ready !== 1'b1 && n < 400) begin n++; @(negedge clk); end
          model_q.push_back(b);
          @(negedge clk);
          wr_valid = 1'b0;
          repeat ($urandom_range(0, 60)) @(negedge clk);
        end
      end
      begin
        for (int k = 0; k < NB; k++) begin
          logic [FRAME_CYC-1:0] w; int wc, bc, lc; bit to;
          logic [7:0] e;
          capture_frame(w, wc, bc, lc, to);
          vectors++;
          if (to || model_q.size() == 0) begin
            miscompares++; $display("FAIL random_frame %0d got timeout=%b queued=%0d want a queued frame", k, to, model_q.size());
          end else begin
            e = model_q.pop_front();
            if (w !== model_wave(e)) begin miscompares++; $display("FAIL random_wave %0d got %h want %h", k, w, model_wave(e)); end
            $display("test_random frame %0d byte=%h wait=%0d", k, e, wc);
          end
        end
      end
    join
  endtask

  initial begin
    test_reset;
    test_single;
    test_queued;
    test_fill;
    test_cts_mid;
    test_reset_mid;
`ifdef UART_PARITY_EN
    test_parity;
`endif
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
